cpu_boot_ctrl: RTL and testbench
================================

Name: cpu_boot_ctrl

Overview:
- Boot/program-load controller sitting between SimpleCPU, an external program-load stream and the single-port blram.
- Holds the CPU in reset and owns the RAM port while it loads a program image word-by-word from address 0.
- Reads the image back to verify a running checksum, then hands the RAM port to the CPU and releases its reset.
- On overflow or checksum mismatch, parks in ERROR with the CPU held in reset.

Parameters:
- SIZE, 10, RAM address width (matches SimpleCPU/blram).
- DEPTH, 1024, RAM word count; maximum image length.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse: begin new load (accepted in any state).
- load_valid  in  1  load word present.
- load_data  in  32  load word.
- load_last  in  1  qualifies final word of image.
- load_ready  out  1  controller accepts a word this cycle.
- cpu_wrEn  in  1  CPU write enable.
- cpu_addr  in  SIZE  CPU address.
- cpu_data  in  32  CPU write data.
- ram_wrEn  out  1  to blram i_we.
- ram_addr  out  SIZE  to blram i_addr.
- ram_data  out  32  to blram i_ram_data_in.
- ram_rdata  in  32  from blram o_ram_data_out (1-cycle read latency).
- cpu_rst  out  1  to SimpleCPU rst (active-high, synchronous at CPU).
- running  out  1  CPU owns RAM and is out of reset.
- error  out  1  sticky until next load_start or reset.
- error_code  out  2  01 overflow, 10 checksum mismatch, 00 none.
- word_count  out  SIZE+1  words accepted in current image.

Behaviour:
- Reset (rst_n=0, async): state IDLE; cpu_rst=1, load_ready=0, running=0, error=0, error_code=00, word_count=0, ram_wrEn=0, ram_addr=0, ram_data=0, checksum accumulators=0.
- States: IDLE, LOAD, VERIFY, DRAIN, CHECK, RUN, ERROR.
- cpu_rst=1 in every state except RUN. cpu_rst is registered: it falls on the clock edge entering RUN.
- RAM mux:
  - In RUN: ram_* = cpu_* combinationally.
  - Elsewhere: driven by the controller.
  - Outside LOAD/VERIFY the controller drives ram_wrEn=0, ram_addr=0, ram_data=0.
- IDLE/RUN/ERROR --load_start--> LOAD. This clears word_count, wptr, both sums and error/error_code. A load_start in RUN re-asserts cpu_rst the next cycle.
- LOAD:
  - load_ready=1.
  - On load_valid & load_ready, same cycle: ram_wrEn=1, ram_addr=wptr, ram_data=load_data.
  - Then wsum += load_data (32-bit, mod 2^32), wptr++, word_count++.
  - Handshake with load_last=1 -> VERIFY with rptr=0.
  - Handshake when word_count==DEPTH (image longer than RAM) -> no write, ERROR, error_code=01.
  - load_last with word_count==DEPTH-1 is legal (exact fill).
- VERIFY:
  - ram_addr=rptr, ram_wrEn=0; rptr++ every cycle; rd_vld registered one cycle behind.
  - When rd_vld=1, rsum += ram_rdata.
  - After issuing address word_count-1 -> DRAIN.
- DRAIN: accumulate the final returned word -> CHECK.
- CHECK (1 cycle):
  - rsum==wsum -> RUN.
  - Otherwise -> ERROR, error_code=10.
- RUN: running=1. Stays in RUN until load_start or reset.
- ERROR: error=1, cpu_rst=1. Stays until load_start or reset.
- load_start has priority over every other event in the same cycle, including a concurrent load handshake. That word is dropped.
- load_ready=0 in all states except LOAD. Total latency, last handshake to running: word_count+3 cycles.
- Reset mid-LOAD/VERIFY: abort immediately. RAM contents are undefined; the CPU stays in reset until a new load completes.

Decomposition:
- Shared package boot_pkg holds:
  - state encoding constants (3-bit, IDLE=0 … ERROR=6);
  - error_code constants ERR_NONE, ERR_OVF, ERR_CSUM.
- One natural sub-module: ram_port_mux (combinational CPU/controller select on ram_wrEn/addr/data). Everything else is in cpu_boot_ctrl.

Test Plan:
- Load 3 words (0x20114045, 0x10114001, 0xB0118064), last on the third -> blram addresses 0..2 written in 3 cycles; reads of 0,1,2 in VERIFY; CHECK passes; cpu_rst falls 6 cycles after the last handshake; running=1; word_count=3.
- Same load, with the bench corrupting blram[1] between LOAD and VERIFY -> error=1, error_code=10, cpu_rst stays 1, running=0.
- DEPTH=4: send 5 words with no load_last -> 4 writes, the 5th is not written, ERROR with error_code=01. DEPTH=4 with 4 words, last on the 4th -> RUN.
- Single word with load_last on the first beat -> VERIFY reads addr 0 only, then RUN; word_count=1.
- In RUN, CPU writes addr 69 = 0x1 -> appears on ram_* the same cycle. load_start pulse -> cpu_rst=1 next cycle, load_ready=1, word_count=0, error cleared.
- rst_n low for 1 cycle mid-LOAD after 2 words -> outputs return to reset values asynchronously; no further ram_wrEn until a new load_start.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the CPU boot/program-load controller.
//   boot_state_e : 3-bit controller state encoding (IDLE=0 .. ERROR=6)
//   ERR_*        : error_code values reported on cpu_boot_ctrl.error_code
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_CHECK  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/ram_port_mux.sv
// Single-port RAM ownership mux: the CPU drives the RAM port while sel_cpu_i
// is high, otherwise the boot controller does. Purely combinational.
//   sel_cpu_i                : 1 = CPU owns the port
//   cpu_we_i/addr_i/data_i   : CPU-side request
//   ctl_we_i/addr_i/data_i   : controller-side request
//   ram_we_o/addr_o/data_o   : to blram
module ram_port_mux #(
    parameter int SIZE = 10
) (
    input  logic            sel_cpu_i,
    input  logic            cpu_we_i,
    input  logic [SIZE-1:0] cpu_addr_i,
    input  logic [31:0]     cpu_data_i,
    input  logic            ctl_we_i,
    input  logic [SIZE-1:0] ctl_addr_i,
    input  logic [31:0]     ctl_data_i,
    output logic            ram_we_o,
    output logic [SIZE-1:0] ram_addr_o,
    output logic [31:0]     ram_data_o
);

    always_comb begin
        if (sel_cpu_i) begin
            ram_we_o   = cpu_we_i;
            ram_addr_o = cpu_addr_i;
            ram_data_o = cpu_data_i;
        end else begin
            ram_we_o   = ctl_we_i;
            ram_addr_o = ctl_addr_i;
            ram_data_o = ctl_data_i;
        end
    end

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/program-load controller between SimpleCPU, a program-load stream and
// the single-port blram. Holds the CPU in reset while an image is written from
// address 0, reads it back to compare checksums, then hands the RAM port to
// the CPU and releases its reset.
//   clk, rst_n                       : clock, async active-low reset
//   load_start/valid/data/last/ready : program-load stream
//   cpu_wrEn/addr/data               : CPU RAM request (passed through in RUN)
//   ram_wrEn/addr/data, ram_rdata    : blram port (1-cycle read latency)
//   cpu_rst, running                 : CPU reset (registered) and RUN flag
//   error, error_code, word_count    : status
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | after reset, CPU held in reset, waiting for load_start
// LOAD   | accepting words, writing them to RAM at wptr, summing into wsum
// VERIFY | issuing read addresses 0..word_count-1, summing returned data
// DRAIN  | collecting the last read word still in flight
// CHECK  | comparing read-back sum against write sum
// RUN    | CPU owns RAM and is out of reset
// ERROR  | overflow or checksum mismatch, CPU held in reset
module cpu_boot_ctrl
    import boot_pkg::*;
#(
    parameter int SIZE  = 10,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            load_valid,
    input  logic [31:0]     load_data,
    input  logic            load_last,
    output logic            load_ready,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    input  logic [31:0]     ram_rdata,
    output logic            cpu_rst,
    output logic            running,
    output logic            error,
    output logic [1:0]      error_code,
    output logic [SIZE:0]   word_count
);

    localparam logic [SIZE:0]   DEPTH_W = (SIZE+1)'(DEPTH);
    localparam logic [SIZE:0]   ONE_W   = (SIZE+1)'(1);
    localparam logic [SIZE-1:0] ONE_P   = SIZE'(1);

    boot_state_e     state_q, state_d;
    logic [SIZE:0]   word_count_q, word_count_d;
    logic [SIZE-1:0] rptr_q, rptr_d;
    logic [31:0]     wsum_q, wsum_d;
    logic [31:0]     rsum_q, rsum_d;
    logic [1:0]      err_q, err_d;
    logic            rd_vld_q, rd_vld_d;
    logic            cpu_rst_q;

    logic            ctl_we;
    logic [SIZE-1:0] ctl_addr;
    logic [31:0]     ctl_data;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        rptr_d       = rptr_q;
        wsum_d       = wsum_q;
        rsum_d       = rsum_q;
        err_d        = err_q;
        ctl_we       = 1'b0;
        ctl_addr     = '0;
        ctl_data     = '0;
        // Read data trails the issued address by one cycle, including the
        // final word that arrives during DRAIN.
        rd_vld_d     = (state_q == ST_VERIFY) && !load_start;

        if (rd_vld_q) begin
            rsum_d = rsum_q + ram_rdata;
        end

        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    if (word_count_q == DEPTH_W) begin
                        // Image does not fit: the extra word is not written.
                        state_d = ST_ERROR;
                        err_d   = ERR_OVF;
                    end else begin
                        ctl_we       = 1'b1;
                        ctl_addr     = word_count_q[SIZE-1:0];
                        ctl_data     = load_data;
                        wsum_d       = wsum_q + load_data;
                        word_count_d = word_count_q + ONE_W;
                        if (load_last) begin
                            state_d = ST_VERIFY;
                            rptr_d  = '0;
                        end
                    end
                end
            end
            ST_VERIFY: begin
                ctl_addr = rptr_q;
                rptr_d   = rptr_q + ONE_P;
                if ({1'b0, rptr_q} == word_count_q - ONE_W) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (rsum_q == wsum_q) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ERROR;
                    err_d   = ERR_CSUM;
                end
            end
            default: ;
        endcase

        // A new load overrides everything else this cycle; a concurrent
        // load word is dropped rather than written.
        if (load_start) begin
            state_d      = ST_LOAD;
            word_count_d = '0;
            rptr_d       = '0;
            wsum_d       = '0;
            rsum_d       = '0;
            err_d        = ERR_NONE;
            ctl_we       = 1'b0;
            ctl_addr     = '0;
            ctl_data     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            rptr_q       <= '0;
            wsum_q       <= '0;
            rsum_q       <= '0;
            err_q        <= ERR_NONE;
            rd_vld_q     <= 1'b0;
            cpu_rst_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            rptr_q       <= rptr_d;
            wsum_q       <= wsum_d;
            rsum_q       <= rsum_d;
            err_q        <= err_d;
            rd_vld_q     <= rd_vld_d;
            cpu_rst_q    <= (state_d != ST_RUN);
        end
    end

    ram_port_mux #(.SIZE(SIZE)) u_mux (
        .sel_cpu_i  (state_q == ST_RUN),
        .cpu_we_i   (cpu_wrEn),
        .cpu_addr_i (cpu_addr),
        .cpu_data_i (cpu_data),
        .ctl_we_i   (ctl_we),
        .ctl_addr_i (ctl_addr),
        .ctl_data_i (ctl_data),
        .ram_we_o   (ram_wrEn),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data)
    );

    assign load_ready = (state_q == ST_LOAD);
    assign running    = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERROR);
    assign error_code = err_q;
    assign word_count = word_count_q;
    assign cpu_rst    = cpu_rst_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
module tb_cpu_boot_ctrl;

    localparam int SIZE  = 10;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            load_start, load_valid, load_last;
    logic [31:0]     load_data;
    logic            load_ready;
    logic            cpu_wrEn;
    logic [SIZE-1:0] cpu_addr;
    logic [31:0]     cpu_data;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic [31:0]     ram_rdata;
    logic            cpu_rst, running, error;
    logic [1:0]      error_code;
    logic [SIZE:0]   word_count;

    always #5 clk = ~clk;

    cpu_boot_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .cpu_wrEn   (cpu_wrEn),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .ram_wrEn   (ram_wrEn),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_rdata  (ram_rdata),
        .cpu_rst    (cpu_rst),
        .running    (running),
        .error      (error),
        .error_code (error_code),
        .word_count (word_count)
    );

    // blram model, read-first, 1-cycle read latency. Corruption is applied on
    // the read path so the stored image seen by VERIFY differs from what LOAD wrote.
    logic [31:0]     mem [0:(1<<SIZE)-1];
    bit              corrupt_on = 1'b0;
    logic [SIZE-1:0] corrupt_idx = '0;
    logic [31:0]     corrupt_mask = 32'h0;
    int              wr_count = 0;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_addr] ^ ((corrupt_on && ram_addr == corrupt_idx) ? corrupt_mask : 32'h0);
        if (ram_wrEn) begin
            mem[ram_addr] <= ram_data;
            wr_count      <= wr_count + 1;
        end
    end

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] img[$];

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = $urandom;
        cpu_wrEn   = 1'($urandom_range(0, 1));
        cpu_addr   = SIZE'($urandom);
        cpu_data   = $urandom;
    endtask

    task automatic check_reset_vals();
        chk_eq("rst_cpu_rst", cpu_rst, 1);
        chk_eq("rst_ready", load_ready, 0);
        chk_eq("rst_running", running, 0);
        chk_eq("rst_error", error, 0);
        chk_eq("rst_code", error_code, 0);
        chk_eq("rst_wcount", word_count, 0);
        chk_eq("rst_we", ram_wrEn, 0);
        chk_eq("rst_addr", ram_addr, 0);
        chk_eq("rst_data", ram_data, 0);
    endtask

    task automatic start_load();
        drive_idle();
        load_start = 1'b1;
        tick();
        drive_idle();
        #1;
        chk_eq("start_cpu_rst", cpu_rst, 1);
        chk_eq("start_ready", load_ready, 1);
        chk_eq("start_wcount", word_count, 0);
        chk_eq("start_error", error, 0);
        chk_eq("start_code", error_code, 0);
        chk_eq("start_running", running, 0);
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input bit exp_we, input int exp_addr);
        drive_idle();
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        chk_eq("load_we", ram_wrEn, exp_we);
        if (exp_we) begin
            chk_eq("load_addr", ram_addr, exp_addr);
            chk_eq("load_data", ram_data, d);
        end
        tick();
        drive_idle();
    endtask

    // Loads img[] and predicts the outcome from the image alone: overflow if
    // it is longer than DEPTH, otherwise RUN iff the read-back sum equals the
    // write sum, reached word_count+3 edges after (and including) the last
    // handshake edge.
    task automatic run_image(input bit give_last, input bit corrupt, input int cidx);
        int          n, wr0, lat, nw;
        bit          ovf, exp_run;
        logic [31:0] wsum, rsum;
        n   = img.size();
        ovf = (n > DEPTH);
        nw  = ovf ? DEPTH : n;
        corrupt_idx  = SIZE'(cidx);
        corrupt_mask = $urandom | 32'h1;
        corrupt_on   = corrupt;
        start_load();
        wr0 = wr_count;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
                drive_idle();
                #1;
                chk_eq("gap_we", ram_wrEn, 0);
                tick();
            end
            send_word(img[i], give_last && (i == n - 1), i < DEPTH, i);
        end
        chk_eq("writes", wr_count - wr0, nw);
        if (ovf) begin
            chk_eq("ovf_error", error, 1);
            chk_eq("ovf_code", error_code, 2'b01);
            chk_eq("ovf_wcount", word_count, DEPTH);
            chk_eq("ovf_cpu_rst", cpu_rst, 1);
            chk_eq("ovf_ready", load_ready, 0);
        end else begin
            wsum = 32'h0;
            rsum = 32'h0;
            for (int i = 0; i < n; i++) begin
                wsum += img[i];
                rsum += (corrupt && i == cidx) ? (img[i] ^ corrupt_mask) : img[i];
            end
            exp_run = (wsum == rsum);
            lat = 1;
            while (cpu_rst && !error && lat < 3 * n + 20) begin
                drive_idle();
                tick();
                lat++;
            end
            chk_eq("latency", lat, n + 3);
            drive_idle();
            #1;
            chk_eq("end_running", running, exp_run);
            chk_eq("end_cpu_rst", cpu_rst, !exp_run);
            chk_eq("end_error", error, !exp_run);
            chk_eq("end_code", error_code, exp_run ? 2'b00 : 2'b10);
            chk_eq("end_wcount", word_count, n);
            if (exp_run) begin
                chk_eq("run_mux_we", ram_wrEn, cpu_wrEn);
                chk_eq("run_mux_addr", ram_addr, cpu_addr);
                chk_eq("run_mux_data", ram_data, cpu_data);
            end
        end
        corrupt_on = 1'b0;
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        tick();

        img = '{32'h20114045, 32'h10114001, 32'hB0118064};
        run_image(1'b1, 1'b0, 0);
        run_image(1'b1, 1'b1, 1);

        fill_random(DEPTH + 1);
        run_image(1'b0, 1'b0, 0);
        fill_random(DEPTH);
        run_image(1'b1, 1'b0, 0);
        fill_random(1);
        run_image(1'b1, 1'b0, 0);

        // CPU write passes straight through while running.
        cpu_wrEn = 1'b1;
        cpu_addr = SIZE'(69);
        cpu_data = 32'h1;
        #1;
        chk_eq("cpu_we", ram_wrEn, 1);
        chk_eq("cpu_addr", ram_addr, 69);
        chk_eq("cpu_data", ram_data, 1);
        start_load();

        // load_start wins over a concurrent handshake.
        send_word(32'hA5A5_0001, 1'b0, 1'b1, 0);
        send_word(32'hA5A5_0002, 1'b0, 1'b1, 1);
        drive_idle();
        load_valid = 1'b1;
        load_start = 1'b1;
        #1;
        chk_eq("prio_we", ram_wrEn, 0);
        tick();
        drive_idle();
        chk_eq("prio_wcount", word_count, 0);
        chk_eq("prio_ready", load_ready, 1);

        // Reset mid-load aborts everything asynchronously.
        send_word(32'h1111_1111, 1'b0, 1'b1, 0);
        send_word(32'h2222_2222, 1'b0, 1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            load_valid = 1'b1;
            #1;
            chk_eq("post_rst_we", ram_wrEn, 0);
            chk_eq("post_rst_ready", load_ready, 0);
            tick();
        end
        drive_idle();

        for (int k = 0; k < 25; k++) begin
            int n;
            bit cor;
            n   = $urandom_range(1, DEPTH + 1);
            cor = (n <= DEPTH) && ($urandom_range(0, 2) == 0);
            fill_random(n);
            run_image(n <= DEPTH, cor, $urandom_range(0, (n <= DEPTH ? n : DEPTH) - 1));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
